// File: rtl/isr_dispatch.sv
// isr_dispatch: upstream feeder for the integer-square-root engine.
//
// Operands arrive on a valid/ready stream and queue in a small FIFO. One job
// at a time is launched: the operand is held on isr_value, the engine is
// loaded with a one-cycle isr_reset pulse, one settle cycle is skipped, and
// then the block waits for isr_done. The root is captured into a one-entry
// output register and presented downstream with the operand echoed.
//
// Ports:
//   clock, reset             system clock; asynchronous active-high reset
//   in_valid/in_value/in_ready   operand stream (64-bit), ready = FIFO not full
//   isr_value, isr_reset     operand held to the engine; engine load pulse
//   isr_result, isr_done     engine root and completion flag
//   out_valid/out_result/out_value/out_ready   result stream with echoed operand
//   busy                     FIFO non-empty, job in flight, or result pending

module isr_dispatch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [63:0] in_value,
    output logic        in_ready,
    output logic [63:0] isr_value,
    output logic        isr_reset,
    input  logic [31:0] isr_result,
    input  logic        isr_done,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic [63:0] out_value,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_SETTLE,
        ST_WAIT
    } state_t;

    state_t state, state_next;

    logic [63:0]    mem [DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           empty, full;
    logic           push, pop, capture;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == ST_IDLE) && !empty;

    // Capture when the engine is done and the output slot is free or being
    // drained this very cycle.
    assign capture  = (state == ST_WAIT) && isr_done && (!out_valid || out_ready);

    // Combinational so that a global reset also resets the engine.
    assign isr_reset = reset || (state == ST_LAUNCH);

    assign busy = !empty || (state != ST_IDLE) || out_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!empty) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_WAIT;
            ST_WAIT:   if (capture) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= in_value;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            isr_value <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                isr_value <= mem[rd_ptr[PTR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_value  <= '0;
        end else begin
            if (capture) begin
                out_valid  <= 1'b1;
                out_result <= isr_result;
                out_value  <= isr_value;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule
